// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output stage.
// Channels are chosen by an explicit select or round-robin, and held for whole packets.
module stream_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          grant,
    output logic                      locked
);

    logic [SEL_W-1:0]    lock_ch_r;
    logic [SEL_W-1:0]    rr_ptr_r;
    logic [SEL_W-1:0]    rr_cand_s;
    logic                rr_ok_s;
    logic [SEL_W-1:0]    cand_s;
    logic                cand_ok_s;
    logic [CHANNELS-1:0] cand_oh_s;
    logic [WIDTH-1:0]    cand_data_s;
    logic                cand_last_s;
    logic                can_accept_s;
    logic                xfer_s;

    assign can_accept_s = !out_valid || out_ready;

    // Round-robin search: walk offsets from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_w;
        logic             hit;
        idx       = 0;
        idx_w     = '0;
        hit       = 1'b0;
        rr_cand_s = '0;
        rr_ok_s   = 1'b0;
        for (int off = CHANNELS; off >= 1; off--) begin
            idx       = (int'(rr_ptr_r) + off) % CHANNELS;
            idx_w     = SEL_W'(idx);
            hit       = in_valid[idx_w];
            rr_cand_s = hit ? idx_w : rr_cand_s;
            rr_ok_s   = rr_ok_s | hit;
        end
    end

    // Candidate selection: an open packet pins the channel, otherwise select or arbitrate.
    always_comb begin
        cand_s    = '0;
        cand_ok_s = 1'b0;
        if (locked) begin
            cand_s    = lock_ch_r;
            cand_ok_s = 1'b1;
        end else if (MODE == 1) begin
            cand_s    = rr_cand_s;
            cand_ok_s = rr_ok_s;
        end else begin
            cand_s    = sel;
            cand_ok_s = (int'(sel) < CHANNELS);
        end
    end

    // One-hot decode of the candidate and AND-OR gathering of its data and last marker.
    always_comb begin
        cand_oh_s   = '0;
        cand_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand_oh_s[i] = cand_ok_s && (cand_s == SEL_W'(i));
            cand_data_s  = cand_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{cand_oh_s[i]}});
        end
    end

    assign cand_last_s = |(in_last & cand_oh_s);
    assign in_ready    = cand_oh_s & {CHANNELS{can_accept_s}};
    assign xfer_s      = |(in_valid & in_ready);

    // Output register, packet lock and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            grant     <= '0;
            locked    <= 1'b0;
            lock_ch_r <= '0;
            rr_ptr_r  <= SEL_W'(CHANNELS - 1);
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= cand_data_s;
            out_last  <= cand_last_s;
            grant     <= cand_s;
            rr_ptr_r  <= cand_s;
            locked    <= !cand_last_s;
            lock_ch_r <= cand_last_s ? lock_ch_r : cand_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
